// File: rtl/mac_unit_core.sv
// mac_unit_core: 8x8 unsigned multiply-accumulate.
//   - mac_out is purely combinational: (a*b + acc) mod 2^16.
//   - The registered path adds a*b to either the external acc or the internal
//     accumulator, and reports a valid pulse and the carry out of bit 15.
// Optional build macro: MAC_UNIT_SAT_EN
//   When defined, the registered accumulator saturates to 16'hFFFF on carry.
//   When undefined, the accumulator wraps modulo 2^16.
//   mac_out always wraps in both builds.
module mac_unit_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] acc,
    input  logic        in_valid,
    input  logic        acc_sel,
    input  logic        clear,
    output logic [15:0] mac_out,
    output logic [15:0] acc_q,
    output logic        out_valid,
    output logic        carry_q
);

    logic [15:0] product;
    logic [16:0] comb_sum;
    logic [15:0] addend;
    logic [16:0] reg_sum;
    logic [15:0] acc_sum_val;

    logic [15:0] acc_reg;
    logic [15:0] acc_next;
    logic        carry_reg;
    logic        carry_next;
    logic        valid_reg;
    logic        valid_next;

    // Product of two 8-bit operands always fits in 16 bits (max 65025).
    assign product  = 16'(a) * 16'(b);

    // Combinational result always uses the external addend and wraps.
    assign comb_sum = {1'b0, product} + {1'b0, acc};
    assign mac_out  = comb_sum[15:0];

    // Registered path may chain onto its own previous result.
    assign addend   = acc_sel ? acc_reg : acc;
    assign reg_sum  = {1'b0, product} + {1'b0, addend};

`ifdef MAC_UNIT_SAT_EN
    // Overflow pins the accumulator at full scale; carry still reports it.
    assign acc_sum_val = reg_sum[16] ? 16'hFFFF : reg_sum[15:0];
`else
    // Overflow simply wraps modulo 2^16.
    assign acc_sum_val = reg_sum[15:0];
`endif

    // Next-state selection: clear beats a new input, otherwise hold.
    always_comb begin
        acc_next   = acc_reg;
        carry_next = carry_reg;
        valid_next = 1'b0;
        if (clear) begin
            acc_next   = 16'd0;
            carry_next = 1'b0;
            valid_next = 1'b0;
        end else if (in_valid) begin
            acc_next   = acc_sum_val;
            carry_next = reg_sum[16];
            valid_next = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= 16'd0;
            carry_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            valid_reg <= valid_next;
        end
    end

    assign acc_q     = acc_reg;
    assign carry_q   = carry_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_mac_unit_core.sv
// tb_mac_unit_core: directed and random checks for mac_unit_core.
// Honors MAC_UNIT_SAT_EN the same way the design does.
module tb_mac_unit_core;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] acc;
    logic        in_valid;
    logic        acc_sel;
    logic        clear;
    logic [15:0] mac_out;
    logic [15:0] acc_q;
    logic        out_valid;
    logic        carry_q;

    int checks;
    int errors;

    // Reference state for the registered path during the random phase.
    logic [15:0] m_acc;
    logic        m_carry;
    logic        m_valid;

    mac_unit_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .in_valid  (in_valid),
        .acc_sel   (acc_sel),
        .clear     (clear),
        .mac_out   (mac_out),
        .acc_q     (acc_q),
        .out_valid (out_valid),
        .carry_q   (carry_q)
    );

    // 10 ns clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference value of (a*b + acc) mod 2^16.
    function automatic logic [15:0] exp_mac(input logic [7:0] x, input logic [7:0] y,
                                             input logic [15:0] z);
        int s;
        s = int'(x) * int'(y) + int'(z);
        return 16'(s % 65536);
    endfunction

    // Advance the reference model by one rising edge.
    task automatic model_step();
        int s;
        int addend_i;
        if (clear) begin
            m_acc   = 16'd0;
            m_carry = 1'b0;
            m_valid = 1'b0;
        end else if (in_valid) begin
            addend_i = acc_sel ? int'(m_acc) : int'(acc);
            s = int'(a) * int'(b) + addend_i;
            m_carry = (s > 65535);
`ifdef MAC_UNIT_SAT_EN
            m_acc = m_carry ? 16'hFFFF : 16'(s % 65536);
`else
            m_acc = 16'(s % 65536);
`endif
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        a        = 8'd0;
        b        = 8'd0;
        acc      = 16'd0;
        in_valid = 1'b0;
        acc_sel  = 1'b0;
        clear    = 1'b0;

        // Reset state
        #1;
        check("rst_acc_q", 32'(acc_q), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_carry_q", 32'(carry_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational directed vectors
        a = 8'd5;   b = 8'd10; acc = 16'd20; #1; check("comb_5x10+20", 32'(mac_out), 32'd70);
        a = 8'd15;  b = 8'd3;  acc = 16'd7;  #1; check("comb_15x3+7", 32'(mac_out), 32'd52);
        a = 8'd255; b = 8'd1;  acc = 16'd0;  #1; check("comb_255x1+0", 32'(mac_out), 32'd255);
        a = 8'd100; b = 8'd2;  acc = 16'd50; #1; check("comb_100x2+50", 32'(mac_out), 32'd250);

        // Wrap-around, combinational and registered
        @(negedge clk);
        a = 8'd255; b = 8'd255; acc = 16'd65535; in_valid = 1'b1; acc_sel = 1'b0;
        #1;
        check("wrap_mac_out", 32'(mac_out), 32'd65024);
        @(posedge clk); #1;
        check("wrap_carry_q", 32'(carry_q), 32'd1);
        check("wrap_out_valid", 32'(out_valid), 32'd1);
`ifdef MAC_UNIT_SAT_EN
        check("wrap_acc_q_sat", 32'(acc_q), 32'd65535);
`else
        check("wrap_acc_q", 32'(acc_q), 32'd65024);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("wrap_valid_pulse", 32'(out_valid), 32'd0);

        // Accumulate from reset: 12, 24, 36
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("acc_rst_acc_q", 32'(acc_q), 32'd0);
        rst_n = 1'b1;
        a = 8'd3; b = 8'd4; acc = 16'd1000; acc_sel = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("accum_acc_q_%0d", i), 32'(acc_q), 32'(12 * i));
            check($sformatf("accum_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("accum_carry_%0d", i), 32'(carry_q), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("accum_valid_end", 32'(out_valid), 32'd0);
        check("accum_hold", 32'(acc_q), 32'd36);

        // Clear beats a simultaneous input
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; a = 8'd2; b = 8'd2;
        @(posedge clk); #1;
        check("clear_acc_q", 32'(acc_q), 32'd0);
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_carry_q", 32'(carry_q), 32'd0);

        // Rebuild 36, then reset asynchronously between edges
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b1; a = 8'd3; b = 8'd4; acc_sel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_async_acc_q", 32'(acc_q), 32'd36);
        check("pre_async_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_acc_q", 32'(acc_q), 32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_carry_q", 32'(carry_q), 32'd0);
        a = 8'd9; b = 8'd7; acc = 16'd1;
        #1;
        check("async_mac_out", 32'(mac_out), 32'd64);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Random phase: mac_out every 5 ns, registered model every cycle
        m_acc   = 16'd0;
        m_carry = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a        = 8'($urandom);
            b        = 8'($urandom);
            acc      = 16'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            acc_sel  = 1'($urandom);
            clear    = ($urandom_range(0, 15) == 0);
            #1;
            check("rand_mac_out", 32'(mac_out), 32'(exp_mac(a, b, acc)));
            model_step();
            @(posedge clk); #1;
            check("rand_acc_q", 32'(acc_q), 32'(m_acc));
            check("rand_carry_q", 32'(carry_q), 32'(m_carry));
            check("rand_out_valid", 32'(out_valid), 32'(m_valid));
            a   = 8'($urandom);
            b   = 8'($urandom);
            acc = 16'($urandom);
            #1;
            check("rand_mac_out_hi", 32'(mac_out), 32'(exp_mac(a, b, acc)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_unit_core.md
Name: mac_unit_core

Overview:
- 8x8 unsigned multiply-accumulate block for the datapath.
- Combinational output: mac_out = a*b + acc, truncated to 16 bits.
- Registered path: accumulates a*b into an internal 16-bit accumulator, with a valid flag and a carry/overflow flag.
- Single clock domain; asynchronous active-low reset.

Parameters:
- none (widths fixed: operands 8 bits, accumulator/result 16 bits)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  8  unsigned multiplicand
- b  input  8  unsigned multiplier
- acc  input  16  unsigned external addend
- in_valid  input  1  qualifies a/b/acc for the registered path
- acc_sel  input  1  0: registered path adds external acc; 1: adds internal accumulator
- clear  input  1  synchronous clear of the internal accumulator
- mac_out  output  16  combinational (a*b + acc) mod 2^16
- acc_q  output  16  registered accumulator value
- out_valid  output  1  acc_q updated on the previous edge
- carry_q  output  1  registered bit 16 of the last accumulated sum

Behaviour:
- Arithmetic: product = a*b, 16 bits unsigned, never overflows (max 65025). Sum = product + addend, 17 bits; bit 16 is carry.
- mac_out: purely combinational, equal to sum[15:0] using the external acc. It does not depend on clk, rst_n, in_valid, acc_sel or clear, and settles within the same delta/timestep. Wrap-around example: 255*255 + 65535 -> 65024.
- Registered addend: addend = acc when acc_sel=0; acc_q when acc_sel=1.
- Reset (rst_n=0, asynchronous): acc_q=0, out_valid=0, carry_q=0 immediately, held while low. Deassertion is sampled on the next rising clk.
- Each rising clk, in priority order:
  1. clear=1: acc_q<=0, carry_q<=0, out_valid<=0. Clear wins over a simultaneous in_valid; that input is dropped.
  2. in_valid=1: acc_q<=sum[15:0], carry_q<=sum[16], out_valid<=1.
  3. Otherwise: acc_q and carry_q hold, out_valid<=0.
- Latency: one clock from in_valid to out_valid/acc_q. Throughput: one operation per clock, back-to-back in_valid allowed. No backpressure.
- out_valid is a single-cycle pulse per accepted input.
- Reset mid-stream: any in-flight result is discarded, and the accumulator restarts from 0.

Optional Feature:
- Macro MAC_UNIT_SAT_EN.
- Defined: on the registered path, if sum[16]=1 then acc_q<=16'hFFFF. carry_q still reports the overflow.
- Undefined: acc_q wraps modulo 2^16.
- mac_out always wraps, in both builds.

Test Plan:
- Combinational directed: a=5,b=10,acc=20 -> mac_out=70; a=15,b=3,acc=7 -> 52; a=255,b=1,acc=0 -> 255; a=100,b=2,acc=50 -> 250. mac_out checked 1 ns after the change with no clock edge.
- Wrap: a=255,b=255,acc=65535 -> mac_out=65024. Registered with acc_sel=0: carry_q=1, acc_q=65024 (65535 with MAC_UNIT_SAT_EN).
- Accumulate: reset, then in_valid=1, acc_sel=1, a=3,b=4 for 3 consecutive cycles -> acc_q 12, 24, 36 on successive edges; out_valid high on each of those 3 cycles, then 0.
- Clear priority: acc_q=36, then clear=1 together with in_valid=1, a=2,b=2 -> acc_q=0, out_valid=0, carry_q=0 next cycle.
- Async reset: assert rst_n=0 between clock edges while acc_q=36 -> acc_q=0, out_valid=0 immediately, without a clock edge. mac_out keeps tracking its inputs.
- Random: 2000 vectors with a,b,acc random and a 5 ns step -> mac_out === (a*b+acc) mod 65536 at every step. Registered model comparison on acc_q/carry_q every cycle.
